// File: rtl/ptp_pdelay_fsm_array_pkg.sv
// ---------------------------------------------------------------------------
// ptp_pdelay_fsm_array_pkg
// Shared definitions for the multi-port Pdelay_Req initiator array:
//   - pdly_state_e     : per-port FSM state, values are the externally
//                        visible state codes (IDLE=0 .. LOST=5)
//   - PDLY_STATE_WIDTH : default width of each per-port state output
// ---------------------------------------------------------------------------
package ptp_pdelay_fsm_array_pkg;

  localparam int unsigned PDLY_STATE_WIDTH = 8;

  typedef enum logic [2:0] {
    PDLY_IDLE        = 3'd0,
    PDLY_SEND_REQ    = 3'd1,
    PDLY_WAIT_RESP   = 3'd2,
    PDLY_WAIT_RESPFW = 3'd3,
    PDLY_DONE        = 3'd4,
    PDLY_LOST        = 3'd5
  } pdly_state_e;

endpackage

// File: rtl/ptp_pdelay_fsm_array_if.sv
// ---------------------------------------------------------------------------
// ptp_pdelay_fsm_array_if
// Groups the per-port event inputs and status outputs of the Pdelay
// initiator array.
//   master : TX/RX event logic and control side (drives i_*, observes o_*)
//   slave  : the initiator array (observes i_*, drives o_*)
// Packed vectors carry port p at bit p (or [p*W +: W] for multi-bit fields).
// ---------------------------------------------------------------------------
interface ptp_pdelay_fsm_array_if #(
  parameter int unsigned NUM_PORTS      = 8,
  parameter int unsigned TIMEOUT_WIDTH  = 24,
  parameter int unsigned LOST_CNT_WIDTH = 4,
  parameter int unsigned SEQ_ID_WIDTH   = 16,
  parameter int unsigned STATE_WIDTH    = 8
);
  logic [NUM_PORTS-1:0]                i_port_enable;
  logic [NUM_PORTS-1:0]                i_twostep;
  logic [TIMEOUT_WIDTH-1:0]            i_resp_timeout;
  logic [NUM_PORTS-1:0]                i_pdelay_start;
  logic [NUM_PORTS-1:0]                i_req_send_end;
  logic [NUM_PORTS-1:0]                i_resp_rec_end;
  logic [NUM_PORTS-1:0]                i_respfw_rec_end;

  logic [NUM_PORTS*STATE_WIDTH-1:0]    o_pdelay_state;
  logic [NUM_PORTS-1:0]                o_pdelay_busy;
  logic                                o_any_busy;
  logic [NUM_PORTS-1:0]                o_pdelay_end;
  logic [NUM_PORTS-1:0]                o_pdelay_timeout;
  logic [NUM_PORTS*LOST_CNT_WIDTH-1:0] o_lost_cnt;
  logic [NUM_PORTS-1:0]                o_as_capable;
  logic [NUM_PORTS*SEQ_ID_WIDTH-1:0]   o_seq_id;

  modport master (
    output i_port_enable, i_twostep, i_resp_timeout, i_pdelay_start,
           i_req_send_end, i_resp_rec_end, i_respfw_rec_end,
    input  o_pdelay_state, o_pdelay_busy, o_any_busy, o_pdelay_end,
           o_pdelay_timeout, o_lost_cnt, o_as_capable, o_seq_id
  );

  modport slave (
    input  i_port_enable, i_twostep, i_resp_timeout, i_pdelay_start,
           i_req_send_end, i_resp_rec_end, i_respfw_rec_end,
    output o_pdelay_state, o_pdelay_busy, o_any_busy, o_pdelay_end,
           o_pdelay_timeout, o_lost_cnt, o_as_capable, o_seq_id
  );
endinterface

// File: rtl/ptp_pdelay_fsm_array_port_fsm.sv
// ---------------------------------------------------------------------------
// ptp_pdelay_port_fsm
// One port's Pdelay_Req initiator: state, response timer, saturating
// lost-response counter, asCapable flag and sequenceId.
// Ports:
//   i_clk, i_rst        clock, async active-low reset
//   i_port_enable       port up and PTP-enabled; low forces IDLE
//   i_twostep           two-step mode, latched on start
//   i_resp_timeout      response timeout in cycles, 0 disables
//   i_pdelay_start      start pulse (honoured only in IDLE)
//   i_req_send_end      Pdelay_Req transmitted
//   i_resp_rec_end      Pdelay_Resp received
//   i_respfw_rec_end    Pdelay_Resp_Follow_Up received
//   o_state/o_busy      state code / state != IDLE
//   o_end/o_timeout     one-cycle success / lost pulses
//   o_lost_cnt          consecutive lost responses
//   o_as_capable        asCapable
//   o_seq_id            sequenceId of current/last request
// ---------------------------------------------------------------------------
module ptp_pdelay_port_fsm
  import ptp_pdelay_fsm_array_pkg::*;
#(
  parameter int unsigned TIMEOUT_WIDTH  = 24,
  parameter int unsigned LOST_CNT_WIDTH = 4,
  parameter int unsigned ALLOWED_LOST   = 3,
  parameter int unsigned SEQ_ID_WIDTH   = 16,
  parameter int unsigned STATE_WIDTH    = PDLY_STATE_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_port_enable,
  input  logic                      i_twostep,
  input  logic [TIMEOUT_WIDTH-1:0]  i_resp_timeout,
  input  logic                      i_pdelay_start,
  input  logic                      i_req_send_end,
  input  logic                      i_resp_rec_end,
  input  logic                      i_respfw_rec_end,
  output logic [STATE_WIDTH-1:0]    o_state,
  output logic                      o_busy,
  output logic                      o_end,
  output logic                      o_timeout,
  output logic [LOST_CNT_WIDTH-1:0] o_lost_cnt,
  output logic                      o_as_capable,
  output logic [SEQ_ID_WIDTH-1:0]   o_seq_id
);

  pdly_state_e               state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0]  timer_q, timer_d;
  logic                      twostep_q, twostep_d;
  logic [LOST_CNT_WIDTH-1:0] lost_q, lost_d;
  logic                      ascap_q, ascap_d;
  logic [SEQ_ID_WIDTH-1:0]   seq_q, seq_d;

  logic [TIMEOUT_WIDTH-1:0]  timer_inc;
  logic [TIMEOUT_WIDTH:0]    timer_next_ext;
  logic                      tmo_hit;
  logic [LOST_CNT_WIDTH-1:0] lost_inc;

  // Timer saturates; compare is done one bit wider so timer+1 never wraps.
  assign timer_inc      = (timer_q == '1) ? timer_q : timer_q + TIMEOUT_WIDTH'(1);
  assign timer_next_ext = {1'b0, timer_q} + (TIMEOUT_WIDTH+1)'(1);
  assign tmo_hit        = (i_resp_timeout != '0) &&
                          (timer_next_ext >= {1'b0, i_resp_timeout});
  assign lost_inc       = (lost_q == '1) ? lost_q : lost_q + LOST_CNT_WIDTH'(1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= PDLY_IDLE;
      timer_q   <= '0;
      twostep_q <= 1'b0;
      lost_q    <= '0;
      ascap_q   <= 1'b0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      twostep_q <= twostep_d;
      lost_q    <= lost_d;
      ascap_q   <= ascap_d;
      seq_q     <= seq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    twostep_d = twostep_q;
    lost_d    = lost_q;
    ascap_d   = ascap_q;
    seq_d     = seq_q;
    if (!i_port_enable) begin
      state_d = PDLY_IDLE;
      lost_d  = '0;
      ascap_d = 1'b0;
    end else begin
      unique case (state_q)
        PDLY_IDLE: begin
          if (i_pdelay_start) begin
            state_d   = PDLY_SEND_REQ;
            seq_d     = seq_q + SEQ_ID_WIDTH'(1);
            twostep_d = i_twostep;
          end
        end
        PDLY_SEND_REQ: begin
          if (i_req_send_end) begin
            state_d = PDLY_WAIT_RESP;
            timer_d = '0;
          end
        end
        PDLY_WAIT_RESP: begin
          timer_d = timer_inc;
          if (i_resp_rec_end) begin
            state_d = twostep_q ? PDLY_WAIT_RESPFW : PDLY_DONE;
            timer_d = '0;
          end else if (tmo_hit) begin
            state_d = PDLY_LOST;
          end
        end
        PDLY_WAIT_RESPFW: begin
          timer_d = timer_inc;
          if (i_respfw_rec_end) begin
            state_d = PDLY_DONE;
          end else if (tmo_hit) begin
            state_d = PDLY_LOST;
          end
        end
        PDLY_DONE: begin
          state_d = PDLY_IDLE;
          lost_d  = '0;
          ascap_d = 1'b1;
        end
        PDLY_LOST: begin
          state_d = PDLY_IDLE;
          lost_d  = lost_inc;
          if (lost_inc > LOST_CNT_WIDTH'(ALLOWED_LOST)) ascap_d = 1'b0;
        end
        default: state_d = PDLY_IDLE;
      endcase
    end
  end

  always_comb begin
    o_state      = STATE_WIDTH'(state_q);
    o_busy       = (state_q != PDLY_IDLE);
    o_end        = (state_q == PDLY_DONE);
    o_timeout    = (state_q == PDLY_LOST);
    o_lost_cnt   = lost_q;
    o_as_capable = ascap_q;
    o_seq_id     = seq_q;
  end

endmodule

// File: rtl/ptp_pdelay_fsm_array.sv
// ---------------------------------------------------------------------------
// ptp_pdelay_fsm_array
// NUM_PORTS independent Pdelay_Req initiator FSMs sharing one clock and one
// response-timeout setting.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-low reset
//   bus    event inputs / status outputs (ptp_pdelay_fsm_array_if.slave);
//          o_any_busy is the OR of all per-port busy bits
// ---------------------------------------------------------------------------
module ptp_pdelay_fsm_array
  import ptp_pdelay_fsm_array_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 8,
  parameter int unsigned TIMEOUT_WIDTH  = 24,
  parameter int unsigned LOST_CNT_WIDTH = 4,
  parameter int unsigned ALLOWED_LOST   = 3,
  parameter int unsigned SEQ_ID_WIDTH   = 16,
  parameter int unsigned STATE_WIDTH    = PDLY_STATE_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  ptp_pdelay_fsm_array_if.slave  bus
);

  logic [STATE_WIDTH-1:0]    state_w [NUM_PORTS];
  logic                      busy_w  [NUM_PORTS];
  logic                      end_w   [NUM_PORTS];
  logic                      tmo_w   [NUM_PORTS];
  logic [LOST_CNT_WIDTH-1:0] lost_w  [NUM_PORTS];
  logic                      ascap_w [NUM_PORTS];
  logic [SEQ_ID_WIDTH-1:0]   seq_w   [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    ptp_pdelay_port_fsm #(
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH),
      .LOST_CNT_WIDTH (LOST_CNT_WIDTH),
      .ALLOWED_LOST   (ALLOWED_LOST),
      .SEQ_ID_WIDTH   (SEQ_ID_WIDTH),
      .STATE_WIDTH    (STATE_WIDTH)
    ) u_fsm (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_port_enable    (bus.i_port_enable[g]),
      .i_twostep        (bus.i_twostep[g]),
      .i_resp_timeout   (bus.i_resp_timeout),
      .i_pdelay_start   (bus.i_pdelay_start[g]),
      .i_req_send_end   (bus.i_req_send_end[g]),
      .i_resp_rec_end   (bus.i_resp_rec_end[g]),
      .i_respfw_rec_end (bus.i_respfw_rec_end[g]),
      .o_state          (state_w[g]),
      .o_busy           (busy_w[g]),
      .o_end            (end_w[g]),
      .o_timeout        (tmo_w[g]),
      .o_lost_cnt       (lost_w[g]),
      .o_as_capable     (ascap_w[g]),
      .o_seq_id         (seq_w[g])
    );
  end

  always_comb begin
    bus.o_pdelay_state   = '0;
    bus.o_pdelay_busy    = '0;
    bus.o_any_busy       = 1'b0;
    bus.o_pdelay_end     = '0;
    bus.o_pdelay_timeout = '0;
    bus.o_lost_cnt       = '0;
    bus.o_as_capable     = '0;
    bus.o_seq_id         = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bus.o_pdelay_state[p*STATE_WIDTH +: STATE_WIDTH]      = state_w[p];
      bus.o_pdelay_busy[p]                                  = busy_w[p];
      bus.o_pdelay_end[p]                                   = end_w[p];
      bus.o_pdelay_timeout[p]                               = tmo_w[p];
      bus.o_lost_cnt[p*LOST_CNT_WIDTH +: LOST_CNT_WIDTH]    = lost_w[p];
      bus.o_as_capable[p]                                   = ascap_w[p];
      bus.o_seq_id[p*SEQ_ID_WIDTH +: SEQ_ID_WIDTH]          = seq_w[p];
      bus.o_any_busy                                        = bus.o_any_busy | busy_w[p];
    end
  end

endmodule
